// File: rtl/bcd_display_scan_if.sv
// Signal bundle between the BCD counters and the MM:SS display scanner.
// master drives the counter values and masks; slave is the scanner.
interface bcd_display_scan_if;
    logic [7:0] MinCount;
    logic [7:0] SecCount;
    logic [3:0] BlinkMask;
    logic [3:0] DpMask;
    logic [3:0] Anode;
    logic [6:0] Seg;
    logic       Dp;
    logic       FrameStrobe;

    modport master (
        output MinCount, SecCount, BlinkMask, DpMask,
        input  Anode, Seg, Dp, FrameStrobe
    );

    modport slave (
        input  MinCount, SecCount, BlinkMask, DpMask,
        output Anode, Seg, Dp, FrameStrobe
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner for MM:SS with frame snapshot,
// dead time, per-digit blink, leading-zero blanking and decimal points.
module bcd_display_scan #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int REFRESH_HZ   = 1_000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 125,
    parameter int LZ_BLANK     = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input logic              Clk,
    input logic              Reset,
    bcd_display_scan_if.slave bus
);
    localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic       POL   = (ACTIVE_LOW != 0);
    localparam logic [3:0] A_OFF = {4{POL}};
    localparam logic [6:0] S_OFF = {7{POL}};

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       slot_tick;
    logic       snap_tick;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic       blank;

    assign slot_tick = (presc_q == P_LAST);
    assign snap_tick = slot_tick && (digit_q == 2'd3);

    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        frame_d = frame_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        if (slot_tick) begin
            presc_d = '0;
            digit_d = digit_q + 1'b1;
        end
        // Frame counter and blink phase only move with a new snapshot
        if (snap_tick) begin
            snap_d  = {bus.MinCount, bus.SecCount};
            frame_d = frame_q + 1'b1;
            if (frame_q == F_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end
        end
    end

    always_comb begin
        nib = 4'd0;
        unique case (digit_q)
            2'd0: nib = snap_q[3:0];
            2'd1: nib = snap_q[7:4];
            2'd2: nib = snap_q[11:8];
            2'd3: nib = snap_q[15:12];
        endcase
    end

    always_comb begin
        glyph = 7'h40;
        unique case (nib)
            4'd0: glyph = 7'h3F;
            4'd1: glyph = 7'h06;
            4'd2: glyph = 7'h5B;
            4'd3: glyph = 7'h4F;
            4'd4: glyph = 7'h66;
            4'd5: glyph = 7'h6D;
            4'd6: glyph = 7'h7D;
            4'd7: glyph = 7'h07;
            4'd8: glyph = 7'h7F;
            4'd9: glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    end

    assign blank = (blink_q && bus.BlinkMask[digit_q])
                 || ((LZ_BLANK != 0) && (digit_q == 2'd3)
                     && (nib == 4'd0));

    // Anodes stay scanned while blanked so every digit keeps equal duty
    always_comb begin
        anode_d = A_OFF;
        if (presc_q >= P_DEAD) begin
            anode_d = (4'b0001 << digit_q) ^ A_OFF;
        end
        seg_d = (blank ? 7'h00 : glyph) ^ S_OFF;
        dp_d  = (!blank && bus.DpMask[digit_q]) ^ POL;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            frame_q <= '0;
            blink_q <= 1'b0;
            snap_q  <= 16'h0000;
            anode_q <= A_OFF;
            seg_q   <= S_OFF;
            dp_q    <= POL;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.Anode       = anode_q;
    assign bus.Seg         = seg_q;
    assign bus.Dp          = dp_q;
    assign bus.FrameStrobe = snap_tick;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: expected slots queued per frame,
// popped by a monitor at each slot start; second instance checks polarity.
module tb_bcd_display_scan;
    logic Clk;
    logic Reset;

    bcd_display_scan_if bus ();
    bcd_display_scan_if bus2 ();

    bcd_display_scan #(
        .CLK_FREQ_HZ(40), .REFRESH_HZ(10), .DEAD_CYCLES(1),
        .BLINK_FRAMES(2), .LZ_BLANK(1), .ACTIVE_LOW(0)
    ) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    bcd_display_scan #(
        .CLK_FREQ_HZ(40), .REFRESH_HZ(10), .DEAD_CYCLES(1),
        .BLINK_FRAMES(2), .LZ_BLANK(1), .ACTIVE_LOW(1)
    ) dut_al (.Clk(Clk), .Reset(Reset), .bus(bus2));

    assign bus2.MinCount  = bus.MinCount;
    assign bus2.SecCount  = bus.SecCount;
    assign bus2.BlinkMask = bus.BlinkMask;
    assign bus2.DpMask    = bus.DpMask;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b1;

    // Frame vectors; expected segments {d3,d2,d1,d0} include blink phase
    logic [7:0]  V_MIN [8] = '{8'h12, 8'h12, 8'h12, 8'h12,
                               8'h05, 8'h05, 8'h98, 8'hA0};
    logic [7:0]  V_SEC [8] = '{8'h34, 8'h35, 8'h35, 8'h35,
                               8'h3C, 8'h3C, 8'h70, 8'h0F};
    logic [3:0]  V_BM  [8] = '{4'h0, 4'h0, 4'h3, 4'h3,
                               4'h3, 4'h3, 4'h0, 4'hF};
    logic [3:0]  V_DM  [8] = '{4'h0, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h4, 4'h9, 4'hF};
    logic [27:0] V_SEG [8] = '{
        {7'h06, 7'h5B, 7'h4F, 7'h66},
        {7'h06, 7'h5B, 7'h4F, 7'h6D},
        {7'h06, 7'h5B, 7'h00, 7'h00},
        {7'h06, 7'h5B, 7'h4F, 7'h6D},
        {7'h00, 7'h6D, 7'h4F, 7'h40},
        {7'h00, 7'h6D, 7'h00, 7'h00},
        {7'h6F, 7'h7F, 7'h07, 7'h3F},
        {7'h40, 7'h3F, 7'h3F, 7'h40}
    };
    logic [3:0]  V_DPX [8] = '{4'h0, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h4, 4'h9, 4'hF};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [27:0] s, input logic [3:0] d);
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            e.an = 4'(1 << j);
            e.sg = s[j*7 +: 7];
            e.dp = d[j];
            q.push_back(e);
        end
    endtask

    // Monitor: one pop per slot at the first active clock of the slot
    logic [3:0] prev_an = 4'h0;
    int         act_cnt = 0;
    always @(negedge Clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.Anode != 4'h0 && prev_an == 4'h0) begin
                if (q.size() == 0) begin
                    chk("unexpected_slot", {28'h0, bus.Anode}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("slot_anode", {28'h0, bus.Anode}, {28'h0, e.an});
                    chk("slot_seg", {25'h0, bus.Seg}, {25'h0, e.sg});
                    chk("slot_dp", {31'h0, bus.Dp}, {31'h0, e.dp});
                    chk("al_anode", {28'h0, bus2.Anode}, {28'h0, ~e.an});
                    chk("al_seg", {25'h0, bus2.Seg}, {25'h0, ~e.sg});
                    chk("al_dp", {31'h0, bus2.Dp}, {31'h0, ~e.dp});
                end
            end
            if (bus.Anode == 4'h0 && prev_an != 4'h0) begin
                chk("active_clocks", act_cnt, 3);
                act_cnt = 0;
            end
            if (bus.Anode != 4'h0) act_cnt++;
        end
        prev_an = bus.Anode;
    end

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge Clk);
            if (bus.FrameStrobe) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int n;
        Reset = 1'b0;
        bus.MinCount  = 8'h00;
        bus.SecCount  = 8'h00;
        bus.BlinkMask = 4'h0;
        bus.DpMask    = 4'h0;
        repeat (3) @(negedge Clk);
        chk("rst_anode", {28'h0, bus.Anode}, 32'h0);
        chk("rst_seg", {25'h0, bus.Seg}, 32'h0);
        chk("rst_dp", {31'h0, bus.Dp}, 32'h0);
        chk("rst_strobe", {31'h0, bus.FrameStrobe}, 32'h0);
        chk("rst_al_anode", {28'h0, bus2.Anode}, 32'hF);
        chk("rst_al_seg", {25'h0, bus2.Seg}, 32'h7F);
        chk("rst_al_dp", {31'h0, bus2.Dp}, 32'h1);

        push_frame({7'h00, 7'h3F, 7'h3F, 7'h3F}, 4'h0);
        Reset = 1'b1;
        repeat (6) @(posedge Clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            bus.MinCount = V_MIN[i];
            bus.SecCount = V_SEC[i];
            wait_strobe(ok);
            if (!ok) begin
                chk("strobe_timeout", 32'h0, 32'h1);
                break;
            end
            @(posedge Clk);
            #1;
            bus.BlinkMask = V_BM[i];
            bus.DpMask    = V_DM[i];
            push_frame(V_SEG[i], V_DPX[i]);
            repeat (6) @(posedge Clk);
            #1;
        end

        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge Clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        mon_en = 1'b0;

        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        chk("async_anode", {28'h0, bus.Anode}, 32'h0);
        chk("async_seg", {25'h0, bus.Seg}, 32'h0);
        chk("async_dp", {31'h0, bus.Dp}, 32'h0);
        chk("async_al_anode", {28'h0, bus2.Anode}, 32'hF);
        chk("async_al_seg", {25'h0, bus2.Seg}, 32'h7F);

        @(negedge Clk);
        Reset = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (bus.FrameStrobe) ok = 1'b1;
        end
        chk("strobe_seen", {31'h0, ok}, 32'h1);
        chk("strobe_clock", n + 1, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
